reg_file_sb: RTL

- Parametrised successor to the core integer register file. Generalised in data width, register count and number of read ports.
- Adds an x0-hardwired-zero rule, write-to-read bypass, and a per-register busy scoreboard that the issue stage sets and writeback clears.
- Sits between decode/issue (read operands, check hazards, mark destination pending) and writeback.

---
 rtl/reg_file_sb.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised integer register file with a per-register busy scoreboard.
//
// Sits between issue and writeback. Issue marks a destination pending, and
// writeback stores data and clears the pending mark. Reads are combinational,
// and a same-cycle writeback is bypassed onto matching read ports. Register 0
// is hardwired to zero and is never busy.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst       - synchronous active-high reset; clears registers, busy bits and busy_cnt
//   wr_en     - writeback strobe
//   wr_addr   - writeback destination
//   wr_data   - writeback data
//   iss_en    - issue strobe; marks iss_addr busy
//   iss_addr  - destination of the instruction being issued
//   rd_addr   - packed read addresses, port k at [k*AW +: AW]
//   rd_data   - packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy   - per-port flag: register has an outstanding producer
//   busy_cnt  - registered count of busy registers
module reg_file_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic [AW:0]         busy_cnt
);

  localparam int unsigned NREGS = 1 << AW;
  localparam logic [AW:0] CntOne = (AW + 1)'(1);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;

  logic wr_valid, iss_valid;
  logic cnt_inc, cnt_dec;

  // Writes or issues to register 0 are dropped.
  assign wr_valid  = wr_en && (wr_addr != '0);
  assign iss_valid = iss_en && (iss_addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_valid) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Set is applied after clear so that a new producer issued in the same cycle
  // as the old producer's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  // Incremental popcount: count only real 0->1 and 1->0 transitions.
  always_comb begin
    cnt_inc    = iss_valid && !busy_q[iss_addr];
    cnt_dec    = wr_valid && busy_q[wr_addr] && !(iss_valid && (iss_addr == wr_addr));
    busy_cnt_d = busy_cnt_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   busy_cnt_d = busy_cnt_q + CntOne;
      2'b01:   busy_cnt_d = busy_cnt_q - CntOne;
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = rd_addr[k*AW +: AW];
    assign hit = wr_en && (wr_addr == ra);
    assign rd_data[k*XLEN +: XLEN] = (ra == '0) ? '0 :
                                     hit        ? wr_data :
                                                  regs_q[ra];
    // A writeback this cycle resolves the hazard since its data is bypassed.
    assign rd_busy[k] = busy_q[ra] && !hit;
  end

endmodule
